// File: rtl/tt_seq_pkg.sv
// Shared definitions for the truth-table sequencer: state encoding and the
// vector / index / mismatch-count widths.
package tt_seq_pkg;

   localparam int NUM_VECTORS = 16;
   localparam int IDX_W       = 4;
   localparam int CNT_W       = 5;
   localparam int SETTLE_W    = 4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_APPLY,
      ST_SETTLE,
      ST_CAPTURE,
      ST_DONE
   } state_e;

endpackage

// File: rtl/tt_index_counter.sv
// Vector index for the sequencer: clears at run start, increments after each
// capture, and flags the final vector so the index never wraps within a run.
module tt_index_counter
   import tt_seq_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   output logic [IDX_W-1:0] idx,
   output logic             last
);

   logic [IDX_W-1:0] idx_d;
   logic [IDX_W-1:0] idx_q;

   always_comb begin
      idx_d = idx_q;
      if (clr) begin
         idx_d = '0;
      end else if (inc && !last) begin
         idx_d = idx_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idx_q <= '0;
      end else begin
         idx_q <= idx_d;
      end
   end

   assign idx  = idx_q;
   assign last = (idx_q == IDX_W'(NUM_VECTORS - 1));

endmodule

// File: rtl/truth_table_sequencer.sv
// Walks a 4-input combinational function through all 16 input vectors,
// captures its truth table and compares it against a golden table.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   ST_IDLE    | waiting for start; results of the last run are held
//   ST_APPLY   | drive {a,b,c,d} with idx, load settle down-counter
//   ST_SETTLE  | wait SETTLE_CYCLES cycles for the function to settle
//   ST_CAPTURE | sample f_in into table_out, compare with expected
//   ST_DONE    | one-cycle done pulse, latch pass
module truth_table_sequencer
   import tt_seq_pkg::*;
#(
   parameter int SETTLE_CYCLES = 2
)
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [NUM_VECTORS-1:0] expected,
   input  logic                   f_in,
   output logic                   a,
   output logic                   b,
   output logic                   c,
   output logic                   d,
   output logic                   busy,
   output logic                   done,
   output logic                   pass,
   output logic [NUM_VECTORS-1:0] table_out,
   output logic [CNT_W-1:0]       err_count,
   output logic [IDX_W-1:0]       first_fail_idx
);

   localparam logic [SETTLE_W-1:0] SETTLE_LD = SETTLE_W'(SETTLE_CYCLES);
   localparam logic                HAS_SETTLE = (SETTLE_CYCLES > 0);

   state_e                 state_d;
   state_e                 state_q;
   logic [IDX_W-1:0]       vec_d;
   logic [IDX_W-1:0]       vec_q;
   logic [SETTLE_W-1:0]    settle_d;
   logic [SETTLE_W-1:0]    settle_q;
   logic [NUM_VECTORS-1:0] table_d;
   logic [NUM_VECTORS-1:0] table_q;
   logic [CNT_W-1:0]       err_d;
   logic [CNT_W-1:0]       err_q;
   logic [IDX_W-1:0]       first_d;
   logic [IDX_W-1:0]       first_q;
   logic                   pass_d;
   logic                   pass_q;

   logic [IDX_W-1:0]       idx;
   logic                   idx_last;
   logic                   idx_clr;
   logic                   idx_inc;
   logic                   mismatch;

   tt_index_counter u_idx (
      .clk  (clk),
      .rst  (rst),
      .clr  (idx_clr),
      .inc  (idx_inc),
      .idx  (idx),
      .last (idx_last)
   );

   assign mismatch = f_in ^ expected[idx];

   always_comb begin
      state_d  = state_q;
      vec_d    = vec_q;
      settle_d = settle_q;
      table_d  = table_q;
      err_d    = err_q;
      first_d  = first_q;
      pass_d   = pass_q;
      idx_clr  = 1'b0;
      idx_inc  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_APPLY;
               idx_clr = 1'b1;
               table_d = '0;
               err_d   = '0;
               first_d = '0;
               pass_d  = 1'b0;
            end
         end

         ST_APPLY: begin
            vec_d    = idx;
            settle_d = SETTLE_LD;
            state_d  = HAS_SETTLE ? ST_SETTLE : ST_CAPTURE;
         end

         // Terminal count at 1 so the state lasts exactly SETTLE_CYCLES cycles.
         ST_SETTLE: begin
            settle_d = settle_q - 1'b1;
            if (settle_q <= SETTLE_W'(1)) begin
               state_d = ST_CAPTURE;
            end
         end

         ST_CAPTURE: begin
            table_d[idx] = f_in;
            if (mismatch) begin
               err_d = err_q + 1'b1;
               if (err_q == '0) begin
                  first_d = idx;
               end
            end
            if (idx_last) begin
               state_d = ST_DONE;
            end else begin
               idx_inc = 1'b1;
               state_d = ST_APPLY;
            end
         end

         ST_DONE: begin
            pass_d  = (err_q == '0);
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         vec_q    <= '0;
         settle_q <= '0;
         table_q  <= '0;
         err_q    <= '0;
         first_q  <= '0;
         pass_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         vec_q    <= vec_d;
         settle_q <= settle_d;
         table_q  <= table_d;
         err_q    <= err_d;
         first_q  <= first_d;
         pass_q   <= pass_d;
      end
   end

   assign {a, b, c, d}   = vec_q;
   assign busy           = (state_q == ST_APPLY) || (state_q == ST_SETTLE) ||
                           (state_q == ST_CAPTURE);
   assign done           = (state_q == ST_DONE);
   assign pass           = pass_q;
   assign table_out      = table_q;
   assign err_count      = err_q;
   assign first_fail_idx = first_q;

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Scoreboard bench: two sequencers (settle 2 and settle 0) driven with directed
// and random truth tables; a negedge monitor checks timing, vectors and results.
module tb_truth_table_sequencer;

   typedef struct packed {
      logic [15:0] tbl;
      logic [4:0]  err;
      logic [3:0]  first;
      logic        pass;
   } res_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_s    [2];
   logic        start_s  [2];
   logic        f_in_s   [2];
   logic        a_s      [2];
   logic        b_s      [2];
   logic        c_s      [2];
   logic        d_s      [2];
   logic        busy_s   [2];
   logic        done_s   [2];
   logic        pass_s   [2];
   logic [15:0] exp_s    [2];
   logic [15:0] tout_s   [2];
   logic [15:0] ftbl     [2];
   logic [4:0]  err_s    [2];
   logic [3:0]  ff_s     [2];
   logic        rst_seen [2];

   int   total = 0;
   int   bad   = 0;
   res_t sb0[$];
   res_t sb1[$];
   int   j_s      [2];
   logic pend_s   [2];
   logic pend_val [2];

   truth_table_sequencer #(.SETTLE_CYCLES(2)) u0 (
      .clk(clk), .rst(rst_s[0]), .start(start_s[0]), .expected(exp_s[0]),
      .f_in(f_in_s[0]), .a(a_s[0]), .b(b_s[0]), .c(c_s[0]), .d(d_s[0]),
      .busy(busy_s[0]), .done(done_s[0]), .pass(pass_s[0]),
      .table_out(tout_s[0]), .err_count(err_s[0]), .first_fail_idx(ff_s[0])
   );

   truth_table_sequencer #(.SETTLE_CYCLES(0)) u1 (
      .clk(clk), .rst(rst_s[1]), .start(start_s[1]), .expected(exp_s[1]),
      .f_in(f_in_s[1]), .a(a_s[1]), .b(b_s[1]), .c(c_s[1]), .d(d_s[1]),
      .busy(busy_s[1]), .done(done_s[1]), .pass(pass_s[1]),
      .table_out(tout_s[1]), .err_count(err_s[1]), .first_fail_idx(ff_s[1])
   );

   // The function under control is a lookup table indexed by the driven vector.
   assign f_in_s[0] = ftbl[0][{a_s[0], b_s[0], c_s[0], d_s[0]}];
   assign f_in_s[1] = ftbl[1][{a_s[1], b_s[1], c_s[1], d_s[1]}];

   always @(posedge clk) begin
      rst_seen[0] <= rst_s[0];
      rst_seen[1] <= rst_s[1];
   end

   function automatic int settle_of(input int k);
      return (k == 0) ? 2 : 0;
   endfunction

   function automatic logic [15:0] and_or_tbl();
      logic [15:0] t;
      logic [3:0]  v;
      for (int i = 0; i < 16; i++) begin
         v    = 4'(i);
         t[i] = (v[3] & v[2]) | (v[1] & v[0]);
      end
      return t;
   endfunction

   function automatic res_t model(input logic [15:0] ft, input logic [15:0] ex);
      res_t        r;
      logic [15:0] diff;
      diff    = ft ^ ex;
      r.tbl   = ft;
      r.err   = 5'd0;
      r.first = 4'd0;
      for (int i = 15; i >= 0; i--) begin
         if (diff[i]) begin
            r.err   = r.err + 5'd1;
            r.first = 4'(i);
         end
      end
      r.pass = (diff == 16'h0);
      return r;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: actual=%0h required=%0h", nm, act, want);
      end
   endtask

   task automatic mon(input int k);
      int   per;
      int   len;
      int   qs;
      res_t r;
      per = settle_of(k) + 2;
      len = 16 * per;
      qs  = (k == 0) ? sb0.size() : sb1.size();
      if (rst_seen[k]) begin
         if (j_s[k] >= 0 && qs > 0) begin
            if (k == 0) void'(sb0.pop_front());
            else        void'(sb1.pop_front());
         end
         j_s[k]    = -1;
         pend_s[k] = 1'b0;
      end else begin
         if (pend_s[k]) begin
            chk($sformatf("u%0d_pass", k), 32'(pass_s[k]), 32'(pend_val[k]));
            pend_s[k] = 1'b0;
         end
         if (j_s[k] < 0) begin
            if (busy_s[k]) j_s[k] = 0;
            else chk($sformatf("u%0d_idle_done", k), 32'(done_s[k]), 32'd0);
         end else begin
            j_s[k]++;
         end
         if (j_s[k] >= 0) begin
            if (j_s[k] < len) begin
               chk($sformatf("u%0d_busy_j%0d", k, j_s[k]),
                   32'({busy_s[k], done_s[k]}), 32'b10);
               if (j_s[k] % per != 0)
                  chk($sformatf("u%0d_vec_j%0d", k, j_s[k]),
                      32'({a_s[k], b_s[k], c_s[k], d_s[k]}), 32'(j_s[k] / per));
            end else begin
               chk($sformatf("u%0d_done_latency", k), 32'({busy_s[k], done_s[k]}), 32'b01);
               if (qs == 0) begin
                  chk($sformatf("u%0d_unexpected_run", k), 32'd0, 32'd1);
               end else begin
                  r = (k == 0) ? sb0.pop_front() : sb1.pop_front();
                  chk($sformatf("u%0d_table_out", k), 32'(tout_s[k]), 32'(r.tbl));
                  chk($sformatf("u%0d_err_count", k), 32'(err_s[k]), 32'(r.err));
                  chk($sformatf("u%0d_first_fail", k), 32'(ff_s[k]), 32'(r.first));
                  pend_val[k] = r.pass;
                  pend_s[k]   = 1'b1;
               end
               j_s[k] = -1;
            end
         end
      end
   endtask

   always @(negedge clk) begin
      mon(0);
      mon(1);
   end

   task automatic push(input int k, input res_t r);
      if (k == 0) sb0.push_back(r);
      else        sb1.push_back(r);
   endtask

   task automatic wait_idle(input int k);
      int n = 0;
      while ((busy_s[k] || done_s[k]) && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (n >= 400) chk($sformatf("u%0d_idle_timeout", k), 32'd0, 32'd1);
   endtask

   task automatic wait_done(input int k);
      int n = 0;
      while (!done_s[k] && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!done_s[k]) chk($sformatf("u%0d_done_timeout", k), 32'd0, 32'd1);
   endtask

   task automatic issue(input int k, input logic [15:0] ft, input logic [15:0] ex,
                        input logic [15:0] ex_eff);
      wait_idle(k);
      ftbl[k]    = ft;
      exp_s[k]   = ex;
      start_s[k] = 1'b1;
      push(k, model(ft, ex_eff));
      @(negedge clk);
      start_s[k] = 1'b0;
   endtask

   task automatic check_reset(input int k);
      chk($sformatf("u%0d_rst_vec", k), 32'({a_s[k], b_s[k], c_s[k], d_s[k]}), 32'd0);
      chk($sformatf("u%0d_rst_busy_done_pass", k),
          32'({busy_s[k], done_s[k], pass_s[k]}), 32'd0);
      chk($sformatf("u%0d_rst_table", k), 32'(tout_s[k]), 32'd0);
      chk($sformatf("u%0d_rst_err", k), 32'(err_s[k]), 32'd0);
      chk($sformatf("u%0d_rst_first", k), 32'(ff_s[k]), 32'd0);
   endtask

   task automatic wait_vec(input int k, input logic [3:0] v);
      int n = 0;
      while (!(busy_s[k] && {a_s[k], b_s[k], c_s[k], d_s[k]} == v) && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk($sformatf("u%0d_reach_vec%0d", k, v), 32'({a_s[k], b_s[k], c_s[k], d_s[k]}), 32'(v));
   endtask

   initial begin
      logic [15:0] fa;
      logic [15:0] e1;
      logic [15:0] e2;
      logic [15:0] ft;
      logic [15:0] ex;
      for (int k = 0; k < 2; k++) begin
         j_s[k]      = -1;
         pend_s[k]   = 1'b0;
         pend_val[k] = 1'b0;
         rst_s[k]    = 1'b1;
         start_s[k]  = 1'b0;
         exp_s[k]    = 16'h0;
         ftbl[k]     = 16'h0;
      end
      fa = and_or_tbl();
      repeat (3) @(negedge clk);
      rst_s[0] = 1'b0;
      rst_s[1] = 1'b0;
      @(negedge clk);
      check_reset(0);
      check_reset(1);

      // Directed runs at the default settle time.
      issue(0, fa, 16'hF888, 16'hF888);  wait_done(0);
      issue(0, fa, 16'hF889, 16'hF889);  wait_done(0);
      issue(0, 16'h0, 16'hF888, 16'hF888); wait_done(0);

      // Abort at vector 5, then a clean run.
      issue(0, fa, 16'hF888, 16'hF888);
      wait_vec(0, 4'd5);
      rst_s[0] = 1'b1;
      @(posedge clk);
      #1;
      rst_s[0] = 1'b0;
      check_reset(0);
      @(negedge clk);
      issue(0, fa, 16'hF888, 16'hF888);  wait_done(0);

      // Golden table changed while vector 8 is settling.
      e1 = 16'($urandom);
      e2 = 16'($urandom);
      issue(0, fa, e1, {e2[15:8], e1[7:0]});
      wait_vec(0, 4'd8);
      exp_s[0] = e2;
      wait_done(0);

      // Zero settle with start held: two back-to-back runs.
      wait_idle(1);
      ftbl[1]    = fa;
      exp_s[1]   = 16'hF888;
      start_s[1] = 1'b1;
      push(1, model(fa, 16'hF888));
      push(1, model(fa, 16'hF888));
      wait_done(1);
      @(negedge clk);
      chk("u1_gap_idle", 32'(busy_s[1]), 32'd0);
      @(negedge clk);
      chk("u1_rerun_accept", 32'(busy_s[1]), 32'd1);
      start_s[1] = 1'b0;
      wait_done(1);

      // Random tables on both instances.
      for (int r = 0; r < 12; r++) begin
         ft = 16'($urandom);
         case (r % 3)
            0:       ex = ft;
            1:       ex = ft ^ (16'h1 << $urandom_range(15, 0));
            default: ex = 16'($urandom);
         endcase
         issue(r % 2, ft, ex, ex);
         wait_done(r % 2);
      end

      repeat (3) @(negedge clk);
      chk("sb0_drained", 32'(sb0.size()), 32'd0);
      chk("sb1_drained", 32'(sb1.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
